// File: rtl/sram_pkg.sv
// Shared SRAM bus definitions for the controller and the device model.
// Bus widths and the device model state encoding.
package sram_pkg;

    localparam int SRAM_AW = 18;
    localparam int SRAM_DW = 16;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_e;

endpackage

// File: rtl/sram_lane_mem.sv
// Halfword array with per-byte write enables and a registered read port.
// A same-cycle write bypasses into the read register lane by lane.
module sram_lane_mem
    import sram_pkg::*;
#(
    parameter int AW = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rd_en,
    input  logic               wr_en,
    input  logic [1:0]         be,
    input  logic [AW-1:0]      idx,
    input  logic [SRAM_DW-1:0] wdata,
    output logic [SRAM_DW-1:0] rdata
);

    logic [SRAM_DW-1:0] mem [2**AW];
    logic [SRAM_DW-1:0] rd_d;
    logic [SRAM_DW-1:0] rd_q;

    always_comb begin
        rd_d = rd_q;
        if (rd_en) begin
            rd_d = mem[idx];
            if (wr_en && be[0]) rd_d[7:0]  = wdata[7:0];
            if (wr_en && be[1]) rd_d[15:8] = wdata[15:8];
        end
    end

    // The array itself is never reset; only the clear sweep zeroes it.
    always_ff @(posedge clk) begin
        if (wr_en && be[0]) mem[idx][7:0]  <= wdata[7:0];
        if (wr_en && be[1]) mem[idx][15:8] <= wdata[15:8];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) rd_q <= '0;
        else     rd_q <= rd_d;
    end

    assign rdata = rd_q;

endmodule

// File: rtl/sram_device_model.sv
// Clocked responder for the 16-bit async SRAM bus (IS61LV25616 pinout).
// Optional post-reset clear sweep, write counters and out-of-range flag.
module sram_device_model
    import sram_pkg::*;
#(
    parameter int MEM_AW     = 10,
    parameter bit CLR_ON_RST = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    inout  wire  [SRAM_DW-1:0] SRAM_DQ,
    input  logic [SRAM_AW-1:0] SRAM_ADDR,
    input  logic               SRAM_WE_N,
    input  logic               SRAM_OE_N,
    input  logic               SRAM_CE_N,
    input  logic               SRAM_UB_N,
    input  logic               SRAM_LB_N,
    output logic               init_busy,
    output logic [15:0]        wr_count,
    output logic [SRAM_AW-1:0] last_wr_adr,
    output logic               oob_err
);

    state_e              state_q, state_d;
    logic [MEM_AW-1:0]   clr_ptr_q, clr_ptr_d;
    logic [15:0]         wr_count_q, wr_count_d;
    logic [SRAM_AW-1:0]  last_wr_adr_q, last_wr_adr_d;
    logic                oob_q, oob_d;

    logic                run, wr_acc, drv, hi_adr;
    logic                mem_we;
    logic [1:0]          mem_be;
    logic [MEM_AW-1:0]   mem_idx;
    logic [SRAM_DW-1:0]  mem_wd;
    logic [SRAM_DW-1:0]  rd_q;

    assign run    = (state_q == ST_RUN);
    assign wr_acc = run && !SRAM_CE_N && !SRAM_WE_N;
    assign drv    = run && !SRAM_CE_N && !SRAM_OE_N && SRAM_WE_N;
    assign hi_adr = |SRAM_ADDR[SRAM_AW-1:MEM_AW];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            if (CLR_ON_RST) state_q <= ST_CLEAR;
            else            state_q <= ST_RUN;
            clr_ptr_q     <= '0;
            wr_count_q    <= '0;
            last_wr_adr_q <= '0;
            oob_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            clr_ptr_q     <= clr_ptr_d;
            wr_count_q    <= wr_count_d;
            last_wr_adr_q <= last_wr_adr_d;
            oob_q         <= oob_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        if (state_q == ST_CLEAR) begin
            clr_ptr_d = clr_ptr_q + {{(MEM_AW-1){1'b0}}, 1'b1};
            if (&clr_ptr_q) state_d = ST_RUN;
        end
    end

    always_comb begin
        init_busy = 1'b0;
        mem_we    = wr_acc;
        mem_be    = {!SRAM_UB_N, !SRAM_LB_N};
        mem_idx   = SRAM_ADDR[MEM_AW-1:0];
        mem_wd    = SRAM_DQ;
        if (state_q == ST_CLEAR) begin
            init_busy = 1'b1;
            mem_we    = 1'b1;
            mem_be    = 2'b11;
            mem_idx   = clr_ptr_q;
            mem_wd    = '0;
        end
    end

    // Counters only move on accepted writes, which cannot happen in CLEAR.
    always_comb begin
        wr_count_d    = wr_count_q;
        last_wr_adr_d = last_wr_adr_q;
        oob_d         = oob_q | ((wr_acc | drv) & hi_adr);
        if (wr_acc) begin
            wr_count_d    = wr_count_q + 16'd1;
            last_wr_adr_d = SRAM_ADDR;
        end
    end

    sram_lane_mem #(
        .AW (MEM_AW)
    ) u_mem (
        .clk   (clk),
        .rst   (rst),
        .rd_en (run),
        .wr_en (mem_we),
        .be    (mem_be),
        .idx   (mem_idx),
        .wdata (mem_wd),
        .rdata (rd_q)
    );

    assign SRAM_DQ[15:8] = (drv && !SRAM_UB_N) ? rd_q[15:8] : 8'bz;
    assign SRAM_DQ[7:0]  = (drv && !SRAM_LB_N) ? rd_q[7:0]  : 8'bz;

    assign wr_count    = wr_count_q;
    assign last_wr_adr = last_wr_adr_q;
    assign oob_err     = oob_q;

endmodule

// File: tb/tb_sram_device_model.sv
// Directed bench for sram_device_model: a small-array clearing instance
// and a 1K-word non-clearing instance share one bus stimulus.
module tb_sram_device_model;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [17:0] addr = '0;
    logic        we_n = 1'b1;
    logic        oe_n = 1'b1;
    logic        ce_n = 1'b1;
    logic        ub_n = 1'b1;
    logic        lb_n = 1'b1;
    logic        tb_oe = 1'b0;
    logic [15:0] tb_dq = '0;

    wire  [15:0] dq4;
    wire  [15:0] dq10;
    logic        busy4, busy10;
    logic [15:0] cnt4, cnt10;
    logic [17:0] last4, last10;
    logic        oob4, oob10;

    int n_cmp = 0;
    int n_bad = 0;

    assign dq4  = tb_oe ? tb_dq : 16'hzzzz;
    assign dq10 = tb_oe ? tb_dq : 16'hzzzz;

    always #5 clk = ~clk;

    sram_device_model #(.MEM_AW(4), .CLR_ON_RST(1'b1)) u_dut4 (
        .clk(clk), .rst(rst), .SRAM_DQ(dq4), .SRAM_ADDR(addr),
        .SRAM_WE_N(we_n), .SRAM_OE_N(oe_n), .SRAM_CE_N(ce_n),
        .SRAM_UB_N(ub_n), .SRAM_LB_N(lb_n), .init_busy(busy4),
        .wr_count(cnt4), .last_wr_adr(last4), .oob_err(oob4)
    );

    sram_device_model #(.MEM_AW(10), .CLR_ON_RST(1'b0)) u_dut10 (
        .clk(clk), .rst(rst), .SRAM_DQ(dq10), .SRAM_ADDR(addr),
        .SRAM_WE_N(we_n), .SRAM_OE_N(oe_n), .SRAM_CE_N(ce_n),
        .SRAM_UB_N(ub_n), .SRAM_LB_N(lb_n), .init_busy(busy10),
        .wr_count(cnt10), .last_wr_adr(last10), .oob_err(oob10)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // An undriven byte reads as z in 4-state tools and 0 in 2-state ones.
    function automatic logic released(input logic [7:0] b);
        return (b === 8'hzz) || (b === 8'h00);
    endfunction

    task automatic idle();
        we_n = 1'b1; oe_n = 1'b1; ce_n = 1'b1;
        ub_n = 1'b1; lb_n = 1'b1; tb_oe = 1'b0;
    endtask

    task automatic wr(input logic [17:0] a, input logic [15:0] d,
                      input logic ub, input logic lb);
        @(negedge clk);
        addr = a; tb_dq = d; tb_oe = 1'b1;
        ce_n = 1'b0; we_n = 1'b0; oe_n = 1'b1;
        ub_n = ub; lb_n = lb;
        @(negedge clk);
        idle();
    endtask

    task automatic rd(input logic [17:0] a, input logic ub, input logic lb,
                      input logic oe);
        @(negedge clk);
        addr = a; tb_oe = 1'b0;
        ce_n = 1'b0; we_n = 1'b1; oe_n = oe;
        ub_n = ub; lb_n = lb;
        @(negedge clk);
        #1;
    endtask

    initial begin
        int cnt;
        logic [15:0] lo, hi;

        repeat (3) @(negedge clk);
        #1;
        chk("rst_busy4", busy4, 1);
        chk("rst_busy10", busy10, 0);
        chk("rst_cnt4", cnt4, 0);
        chk("rst_last4", last4, 0);
        chk("rst_oob4", oob4, 0);

        // Clear sweep length and contents
        @(negedge clk);
        rst = 1'b0;
        #1;
        cnt = 0;
        while (busy4 && cnt < 100) begin
            cnt++;
            @(negedge clk);
            #1;
        end
        chk("clr_len", cnt, 16);
        for (int i = 0; i < 16; i++) begin
            rd(18'(i), 1'b0, 1'b0, 1'b0);
            chk($sformatf("clr_rd%0d", i), dq4, 16'h0000);
        end
        idle();

        // Single write then read back
        wr(18'h00004, 16'hBEEF, 1'b0, 1'b0);
        rd(18'h00004, 1'b0, 1'b0, 1'b0);
        chk("wr_rd4", dq4, 16'hBEEF);
        chk("wr_cnt1", cnt4, 1);
        chk("wr_last", last4, 18'h00004);
        chk("oob4_clean", oob4, 0);

        // Back-to-back halfword pair read as a 32-bit word
        wr(18'h00010, 16'h5678, 1'b0, 1'b0);
        wr(18'h00011, 16'h1234, 1'b0, 1'b0);
        @(negedge clk);
        addr = 18'h00010; ce_n = 1'b0; oe_n = 1'b0;
        ub_n = 1'b0; lb_n = 1'b0;
        @(negedge clk);
        addr = 18'h00011;
        #1;
        lo = dq10;
        @(negedge clk);
        #1;
        hi = dq10;
        chk("pair10", {hi, lo}, 32'h12345678);
        chk("oob4_alias", oob4, 1);
        chk("oob10_clean", oob10, 0);
        chk("cnt10_3", cnt10, 3);
        idle();

        // Byte lanes
        wr(18'h00003, 16'hAAAA, 1'b0, 1'b0);
        wr(18'h00003, 16'h5511, 1'b1, 1'b0);
        rd(18'h00003, 1'b0, 1'b0, 1'b0);
        chk("lane_both", dq4, 16'hAA11);
        rd(18'h00003, 1'b1, 1'b0, 1'b0);
        chk("lane_lo", dq4[7:0], 8'h11);
        chk("lane_hi_off", released(dq4[15:8]), 1);
        rd(18'h00003, 1'b0, 1'b0, 1'b1);
        chk("oe_off", released(dq4[15:8]) & released(dq4[7:0]), 1);

        // Aliased out-of-range write
        wr(18'h00402, 16'hC0DE, 1'b0, 1'b0);
        chk("oob10_set", oob10, 1);
        chk("last10", last10, 18'h00402);
        rd(18'h00002, 1'b0, 1'b0, 1'b0);
        chk("alias10", dq10, 16'hC0DE);
        chk("oob10_sticky", oob10, 1);

        // Accepted write with both lanes off
        wr(18'h00005, 16'hFFFF, 1'b1, 1'b1);
        chk("nolane_cnt", cnt4, 7);
        rd(18'h00005, 1'b0, 1'b0, 1'b0);
        chk("nolane_mem", dq4, 16'h0000);
        idle();

        // Reset mid-sweep restarts the clear from zero
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mid_busy", busy4, 1);
        chk("mid_cnt", cnt4, 0);
        chk("mid_last", last4, 0);
        chk("mid_oob", oob4, 0);
        @(negedge clk);
        rst = 1'b0;
        ce_n = 1'b0; we_n = 1'b0; oe_n = 1'b0;
        ub_n = 1'b0; lb_n = 1'b0;
        #1;
        cnt = 0;
        while (busy4 && cnt < 100) begin
            cnt++;
            if (cnt == 2)
                chk("clr_we_rel",
                    released(dq4[15:8]) & released(dq4[7:0]), 1);
            if (cnt == 3) idle();
            @(negedge clk);
            #1;
        end
        chk("reclr_len", cnt, 16);
        chk("reclr_cnt", cnt4, 0);
        rd(18'h00004, 1'b0, 1'b0, 1'b0);
        chk("reclr_mem", dq4, 16'h0000);
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
